button_pulse_conditioner: RTL



---
 rtl/button_pulse_conditioner.sv | 127 ++++++++++++
 1 files changed

// File: rtl/button_pulse_conditioner.sv
// Turns a raw, bouncing pushbutton into one-cycle increment strobes plus a debounced level.
// Hold-to-repeat is compiled in only when AUTOREPEAT_EN is defined.
module button_pulse_conditioner #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic en,
  output logic pulse_out,
  output logic level_out
);

`ifdef AUTOREPEAT_EN
  localparam int CntMaxA = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int CntMax  = (CntMaxA > REPEAT_PERIOD) ? CntMaxA : REPEAT_PERIOD;
`else
  localparam int CntMax  = DEB_CYCLES;
`endif
  localparam int CW = $clog2(CntMax) + 1;

  localparam logic [CW-1:0] DebLast = CW'(DEB_CYCLES - 1);
`ifdef AUTOREPEAT_EN
  localparam logic [CW-1:0] DelayLast  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PeriodLast = CW'(REPEAT_PERIOD - 1);
`endif

  if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParams
    $error("button_pulse_conditioner: all cycle parameters must be >= 1");
  end

`ifdef AUTOREPEAT_EN
  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REPEAT, RELEASE_CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;
`endif

  state_t          state_q;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q;
  logic            pulse_q;
  logic            level_q;
  logic            btn_s;

  assign btn_s     = sync_q[1];
  assign pulse_out = pulse_q;
  assign level_out = level_q;

  // A btn_s change always wins over a terminal count; cnt is cleared on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_in};
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (btn_s) state_q <= PRESS_CHK;
        end
        PRESS_CHK: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DebLast) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= en;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= RELEASE_CHK;
            cnt_q   <= '0;
`ifdef AUTOREPEAT_EN
          end else if (cnt_q == DelayLast) begin
            state_q <= REPEAT;
            cnt_q   <= '0;
            pulse_q <= en;
          end else begin
            cnt_q <= cnt_q + CW'(1);
`endif
          end
        end
`ifdef AUTOREPEAT_EN
        REPEAT: begin
          if (!btn_s) begin
            state_q <= RELEASE_CHK;
            cnt_q   <= '0;
          end else if (cnt_q == PeriodLast) begin
            cnt_q   <= '0;
            pulse_q <= en;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        RELEASE_CHK: begin
          if (btn_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DebLast) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
